// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin grant and a blocking load window.
// Stores complete in the grant cycle; a load holds the arbiter BUSY for MEM_LAT cycles
// and returns mem_rdata to the loading port.
// Optional build macro DMEM_ARB_MISALIGN_CHK_EN: reject addr[1:0] != 0 with an error pulse.
module dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rr_q, rr_d;        // 1: p1 wins the next contested grant
  logic          ld_port_q, ld_port_d;

  logic          sel_p1;
  logic          grant;
  logic          misalign;
  logic          issue;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rd_fire;

  // Pick the requester and decide whether the access reaches memory this cycle.
  always_comb begin
    sel_p1 = 1'b0;
    if (p0_req && p1_req) begin
      sel_p1 = rr_q;
    end else begin
      sel_p1 = p1_req;
    end
    sel_we    = sel_p1 ? p1_we    : p0_we;
    sel_addr  = sel_p1 ? p1_addr  : p0_addr;
    sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
    grant     = ~rst && (state_q == StIdle) && (p0_req || p1_req);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    misalign  = (sel_addr[1:0] != 2'b00);
`else
    misalign  = 1'b0;
`endif
    issue     = grant && !misalign;
    rd_fire   = ~rst && (state_q == StBusy) && (cnt_q == 4'd1);
  end

  // Drive grants, memory strobes and load returns; everything idles at zero.
  always_comb begin
    p0_gnt    = grant && !sel_p1;
    p1_gnt    = grant && sel_p1;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    p0_err    = p0_gnt && misalign;
    p1_err    = p1_gnt && misalign;
`else
    p0_err    = 1'b0;
    p1_err    = 1'b0;
`endif
    mem_en    = issue;
    mem_we    = issue && sel_we;
    mem_addr  = issue ? sel_addr  : '0;
    mem_wdata = issue ? sel_wdata : '0;
    p0_rvalid = rd_fire && !ld_port_q;
    p1_rvalid = rd_fire && ld_port_q;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

  // Next-state: loads open a MEM_LAT-cycle busy window; every grant moves the pointer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    ld_port_d = ld_port_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          rr_d = ~sel_p1;
        end
        if (issue && !sel_we) begin
          state_d   = StBusy;
          cnt_d     = 4'(MEM_LAT);
          ld_port_d = sel_p1;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any load in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rr_q      <= 1'b0;
      ld_port_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      ld_port_q <= ld_port_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter. The stimulus process predicts grants and
// load returns from cycle arithmetic (last winner, first free cycle) and queues them; the
// monitor compares every cycle on the falling edge.
module tb_dmem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int          NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  typedef struct {
    int            c;
    bit            port;
    bit            err;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct {
    int            c;
    bit            port;
    logic [DW-1:0] data;
  } rv_t;

  gnt_t gq[$];
  rv_t  rq[$];
  gnt_t mg;
  rv_t  mr;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_on = 1'b0;
  bit   seen_g0 = 1'b0;
  bit   seen_g1 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_pat(int c);
    return (DW'(c) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign mem_rdata = rd_pat(cyc);

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
  endtask

  // Monitor: compare DUT outputs against queued predictions.
  always @(negedge clk) begin
    if (mon_on) begin
      seen_g0 <= p0_gnt;
      seen_g1 <= p1_gnt;
      if (rst) begin
        check("rst_ctl", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_en, mem_we},
              64'd0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 64'd0);
        check("rst_mem", {mem_addr, mem_wdata}, 64'd0);
      end else begin
        if (gq.size() != 0 && gq[0].c == cyc) begin
          mg = gq.pop_front();
          check("gnt", {p1_gnt, p0_gnt}, mg.port ? 64'd2 : 64'd1);
          check("err", {p1_err, p0_err}, mg.err ? (mg.port ? 64'd2 : 64'd1) : 64'd0);
          check("mem_en", mem_en, {63'd0, !mg.err});
          if (!mg.err) begin
            check("mem_we", mem_we, {63'd0, mg.we});
            check("mem_addr", mem_addr, mg.addr);
            check("mem_wdata", mem_wdata, mg.wdata);
          end
        end else begin
          check("no_gnt", {p1_gnt, p0_gnt, mem_en}, 64'd0);
          check("no_err", {p1_err, p0_err}, 64'd0);
        end
        if (!mem_en) begin
          check("mem_quiet_a", {mem_we, mem_addr}, 64'd0);
          check("mem_quiet_d", mem_wdata, 64'd0);
        end
        if (rq.size() != 0 && rq[0].c == cyc) begin
          mr = rq.pop_front();
          check("rvalid", {p1_rvalid, p0_rvalid}, mr.port ? 64'd2 : 64'd1);
          check("rdata", mr.port ? p1_rdata : p0_rdata, mr.data);
        end else begin
          check("no_rvalid", {p1_rvalid, p0_rvalid}, 64'd0);
        end
        if (!p0_rvalid) check("p0_rdata_zero", p0_rdata, 64'd0);
        if (!p1_rvalid) check("p1_rdata_zero", p1_rdata, 64'd0);
      end
    end
  end

  // Stimulus plus reference model.
  initial begin
    int   free_c;
    bit   last;
    bit   win;
    bit   mis;
    int   rst_left;
    gnt_t g;
    rv_t  r;
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    free_c = 0;
    last = 1'b1;  // p0 wins the first contested grant
    rst_left = 0;
    #1 mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc++;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (seen_g0) p0_req = 1'b0;
      if (seen_g1) p1_req = 1'b0;
      if (rst) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_left = 2;
        rq.delete();
        free_c = 0;
        last = 1'b1;
      end
      if (!p0_req && $urandom_range(0, 2) != 0) begin
        p0_req = 1'b1; p0_we = 1'($urandom_range(0, 1));
        p0_addr = $urandom; p0_wdata = $urandom;
        if ($urandom_range(0, 3) != 0) p0_addr[1:0] = 2'b00;
      end
      if (!p1_req && $urandom_range(0, 2) != 0) begin
        p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
        p1_addr = $urandom; p1_wdata = $urandom;
        if ($urandom_range(0, 3) != 0) p1_addr[1:0] = 2'b00;
      end
      if (!rst && cyc >= free_c && (p0_req || p1_req)) begin
        win  = (p0_req && p1_req) ? !last : p1_req;
        last = win;
        g.c     = cyc;
        g.port  = win;
        g.we    = win ? p1_we : p0_we;
        g.addr  = win ? p1_addr : p0_addr;
        g.wdata = win ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        mis = (g.addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        g.err = mis;
        gq.push_back(g);
        if (!g.we && !mis) begin
          r.c    = cyc + int'(LAT);
          r.port = win;
          r.data = rd_pat(cyc + int'(LAT));
          rq.push_back(r);
          free_c = cyc + int'(LAT) + 1;
        end
      end
    end
    // Drain: stop requesting and let outstanding loads return.
    repeat (LAT + 3) begin
      @(posedge clk);
      #1;
      cyc++;
      p0_req = 1'b0;
      p1_req = 1'b0;
      rst = 1'b0;
    end
    check("drain_rq", rq.size(), 64'd0);
    check("drain_gq", gq.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
